stack_upstream_arbiter: RTL and testbench

//  Shares the PE upstream stack-bus path (the sui__sti__* input of the stack interface) between
//  NUM_REQ packet sources (SIMD, DMA, PE control). Packet-locked round-robin arbitration with
//  SOP/EOP framing on cntl; one registered output stage; sticky protocol/stall status.

---
 rtl/stack_upstream_arbiter_pkg.sv | 33 +++
 rtl/stack_upstream_arbiter_if.sv | 35 +++
 rtl/stack_upstream_arbiter_rr_pick.sv | 32 +++
 rtl/stack_upstream_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_stack_upstream_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_upstream_arbiter_pkg.sv
// Shared constants and helpers for the upstream stack-bus arbiter.
// Cntl framing codes, FSM state and default widths.
package stack_up_arb_pkg;

  localparam logic [1:0] CNTL_MOP     = 2'b00;
  localparam logic [1:0] CNTL_SOP     = 2'b01;
  localparam logic [1:0] CNTL_EOP     = 2'b10;
  localparam logic [1:0] CNTL_SOP_EOP = 2'b11;

  localparam int DEF_NUM_REQ   = 3;
  localparam int DEF_TYPE_W    = 2;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_OOB_W     = 32;
  localparam int DEF_MAX_STALL = 255;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic is_start(input logic [1:0] c);
    return (c == CNTL_SOP) || (c == CNTL_SOP_EOP);
  endfunction

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/stack_upstream_arbiter_if.sv
// Valid/ready beat bus, N lanes wide; master drives beats, slave drives ready.
// Used for both the requester side (N=NUM_REQ) and the stack side (N=1).
interface stack_upstream_arbiter_if #(
  parameter int N      = 1,
  parameter int TYPE_W = 2,
  parameter int DATA_W = 64,
  parameter int OOB_W  = 32
);

  logic [N-1:0]        valid;
  logic [2*N-1:0]      cntl;
  logic [N-1:0]        ready;
  logic [TYPE_W*N-1:0] pkt_type;
  logic [DATA_W*N-1:0] data;
  logic [OOB_W*N-1:0]  oob_data;

  modport master (
    output valid,
    output cntl,
    output pkt_type,
    output data,
    output oob_data,
    input  ready
  );

  modport slave (
    input  valid,
    input  cntl,
    input  pkt_type,
    input  data,
    input  oob_data,
    output ready
  );

endinterface

// File: rtl/stack_upstream_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot winner, zero when nothing requests.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win
);

  int               s;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    s     = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = PTR_W'(s);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_upstream_arbiter.sv
// Packet-locked round-robin arbiter for the PE upstream stack bus.
// One registered output stage; sticky framing-error and stall flags.
module stack_upstream_arbiter
  import stack_up_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int TYPE_W    = DEF_TYPE_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OOB_W     = DEF_OOB_W,
  parameter int MAX_STALL = DEF_MAX_STALL
) (
  input  logic                clk,
  input  logic                reset_poweron,
  stack_upstream_arbiter_if.slave  req,
  stack_upstream_arbiter_if.master sti,
  output logic [NUM_REQ-1:0]  arb__grant,
  output logic [NUM_REQ-1:0]  arb__proto_err,
  output logic                arb__stall
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_STALL + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               stall_q;
  logic [NUM_REQ-1:0] err_q, err_set;

  logic [NUM_REQ-1:0] start_v, cand, win, rdy;
  logic               slot_free, accept, owner_valid;

  logic [1:0]         sel_cntl;
  logic [TYPE_W-1:0]  sel_type;
  logic [DATA_W-1:0]  sel_data;
  logic [OOB_W-1:0]   sel_oob;

  logic               out_valid_q;
  logic [1:0]         out_cntl_q;
  logic [TYPE_W-1:0]  out_type_q;
  logic [DATA_W-1:0]  out_data_q;
  logic [OOB_W-1:0]   out_oob_q;

  function automatic logic [PTR_W-1:0] next_ptr(
    input logic [2:0] i
  );
    if (int'(i) == NUM_REQ - 1) return '0;
    return PTR_W'(int'(i) + 1);
  endfunction

  always_comb begin
    start_v = '0;
    for (int i = 0; i < NUM_REQ; i++)
      start_v[i] = is_start(req.cntl[2*i +: 2]);
  end

  assign cand = req.valid & start_v;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (cand),
    .ptr (ptr_q),
    .win (win)
  );

  assign slot_free   = !out_valid_q || sti.ready[0];
  assign owner_valid = |(owner_q & req.valid);

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_cntl == CNTL_SOP) begin
            state_d = LOCKED;
            owner_d = win;
          end else begin
            ptr_d = next_ptr(oh2idx(8'(win)));
          end
        end
      end
      LOCKED: begin
        if (accept && sel_cntl == CNTL_EOP) begin
          state_d = IDLE;
          owner_d = '0;
          ptr_d   = next_ptr(oh2idx(8'(owner_q)));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy        = '0;
    arb__grant = '0;
    unique case (state_q)
      IDLE:    if (slot_free) rdy = win;
      LOCKED: begin
        arb__grant = owner_q;
        if (slot_free) rdy = owner_q & req.valid;
      end
      default: rdy = '0;
    endcase
  end

  assign req.ready = rdy;
  assign accept    = |rdy;

  always_comb begin
    sel_cntl = '0;
    sel_type = '0;
    sel_data = '0;
    sel_oob  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i]) begin
        sel_cntl = req.cntl[2*i +: 2];
        sel_type = req.pkt_type[TYPE_W*i +: TYPE_W];
        sel_data = req.data[DATA_W*i +: DATA_W];
        sel_oob  = req.oob_data[OOB_W*i +: OOB_W];
      end
    end
  end

  // Non-owners may only offer starts; owners may not restart mid-packet.
  always_comb begin
    err_set = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      err_set[i] = (req.valid[i] && !start_v[i] &&
                    !(state_q == LOCKED && owner_q[i])) ||
                   (state_q == LOCKED && rdy[i] && start_v[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      err_q   <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      err_q   <= err_q | err_set;
      stall_q <= stall_q || (cnt_q == CNT_W'(MAX_STALL));
      if (state_q == LOCKED) begin
        if (accept)
          cnt_q <= '0;
        else if (!owner_valid && cnt_q != CNT_W'(MAX_STALL))
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      out_valid_q <= 1'b0;
      out_cntl_q  <= '0;
      out_type_q  <= '0;
      out_data_q  <= '0;
      out_oob_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_cntl_q  <= sel_cntl;
      out_type_q  <= sel_type;
      out_data_q  <= sel_data;
      out_oob_q   <= sel_oob;
    end else if (sti.ready[0]) begin
      out_valid_q <= 1'b0;
    end
  end

  assign sti.valid      = out_valid_q;
  assign sti.cntl       = out_cntl_q;
  assign sti.pkt_type   = out_type_q;
  assign sti.data       = out_data_q;
  assign sti.oob_data   = out_oob_q;
  assign arb__proto_err = err_q;
  assign arb__stall     = stall_q;

endmodule

// File: tb/tb_stack_upstream_arbiter.sv
// Bench for stack_upstream_arbiter: directed scenarios plus random
// packet traffic checked against a packet-level reference model.
module tb_stack_upstream_arbiter;

  localparam int N  = 3;
  localparam int TW = 2;
  localparam int DW = 64;
  localparam int OW = 32;
  localparam int MS = 255;

  localparam logic [1:0] MOP = 2'b00;
  localparam logic [1:0] SOP = 2'b01;
  localparam logic [1:0] EOP = 2'b10;
  localparam logic [1:0] SE  = 2'b11;

  typedef struct packed {
    logic [1:0]    cntl;
    logic [TW-1:0] typ;
    logic [DW-1:0] data;
    logic [OW-1:0] oob;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stack_upstream_arbiter_if #(.N(N), .TYPE_W(TW), .DATA_W(DW), .OOB_W(OW)) req_if ();
  stack_upstream_arbiter_if #(.N(1), .TYPE_W(TW), .DATA_W(DW), .OOB_W(OW)) sti_if ();

  logic [N-1:0] grant, perr;
  logic         stall;

  stack_upstream_arbiter #(
    .NUM_REQ(N), .TYPE_W(TW), .DATA_W(DW), .OOB_W(OW), .MAX_STALL(MS)
  ) dut (
    .clk            (clk),
    .reset_poweron  (rst_n),
    .req            (req_if.slave),
    .sti            (sti_if.master),
    .arb__grant     (grant),
    .arb__proto_err (perr),
    .arb__stall     (stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  beat_t        src_q[N][$];
  int           seq[N];
  logic [N-1:0] en;
  int           p_valid = 100;
  int           p_ready = 100;
  int           sti_hold = 0;

  bit           m_locked;
  int           m_owner, m_ptr, m_idle, n_in, n_out;
  bit           m_full, m_stall;
  beat_t        m_out;
  logic [N-1:0] m_err;
  int           out_log[$];

  function automatic bit starts(input logic [1:0] c);
    return c == SOP || c == SE;
  endfunction

  task automatic push_raw(input int s, input logic [1:0] c);
    beat_t b;
    b.cntl = c;
    b.typ  = TW'($urandom);
    b.data = {8'(s), 24'(seq[s]), 32'($urandom)};
    b.oob  = OW'($urandom);
    seq[s]++;
    src_q[s].push_back(b);
  endtask

  task automatic push_pkt(input int s, input int len);
    for (int b = 0; b < len; b++) begin
      if (len == 1)          push_raw(s, SE);
      else if (b == 0)       push_raw(s, SOP);
      else if (b == len - 1) push_raw(s, EOP);
      else                   push_raw(s, MOP);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      beat_t b;
      b = '0;
      en[i] = src_q[i].size() > 0 && $urandom_range(99) < p_valid;
      if (src_q[i].size() > 0) b = src_q[i][0];
      req_if.valid[i]             = en[i];
      req_if.cntl[2*i +: 2]       = b.cntl;
      req_if.pkt_type[i*TW +: TW] = b.typ;
      req_if.data[i*DW +: DW]     = b.data;
      req_if.oob_data[i*OW +: OW] = b.oob;
    end
    if (sti_hold > 0) begin
      sti_if.ready[0] = 1'b0;
      sti_hold--;
    end else begin
      sti_if.ready[0] = $urandom_range(99) < p_ready;
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
    m_full = 0; m_stall = 0; m_err = '0; m_out = '0;
    n_in = 0; n_out = 0;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_rdy, exp_gnt;
    bit           slot, sti_acc;
    int           f, idx;
    beat_t        b;
    @(negedge clk);
    exp_rdy = '0;
    exp_gnt = '0;
    if (m_locked) exp_gnt[m_owner] = 1'b1;
    slot = !m_full || sti_if.ready[0];
    if (slot) begin
      if (m_locked) begin
        if (en[m_owner]) exp_rdy[m_owner] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (exp_rdy == '0 && en[idx] && starts(src_q[idx][0].cntl))
            exp_rdy[idx] = 1'b1;
        end
      end
    end
    check("ready", req_if.ready, exp_rdy);
    check("grant", grant, exp_gnt);
    check("out_valid", sti_if.valid, m_full);
    if (m_full)
      check("out_beat", {sti_if.cntl, sti_if.pkt_type, sti_if.data,
                         sti_if.oob_data}, m_out);
    check("proto_err", perr, m_err);
    check("stall", stall, m_stall);

    f = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) f = i;
    sti_acc = m_full && sti_if.ready[0];
    if (sti_acc) begin
      n_out++;
      out_log.push_back(int'(m_out.data[63:56]));
    end
    for (int i = 0; i < N; i++)
      if (en[i] && !starts(src_q[i][0].cntl) && !(m_locked && m_owner == i))
        m_err[i] = 1'b1;
    if (m_idle >= MS) m_stall = 1;
    if (f >= 0) begin
      b = src_q[f][0];
      if (m_locked && starts(b.cntl)) m_err[f] = 1'b1;
      m_out = b; m_full = 1; n_in++; m_idle = 0;
      if (!m_locked) begin
        if (b.cntl == SOP) begin m_locked = 1; m_owner = f; end
        else m_ptr = (f + 1) % N;
      end else if (b.cntl == EOP) begin
        m_locked = 0;
        m_ptr = (f + 1) % N;
      end
    end else begin
      if (sti_acc) m_full = 0;
      if (m_locked && !en[m_owner]) m_idle++;
    end
    @(posedge clk);
    #1;
    if (f >= 0) void'(src_q[f].pop_front());
    drive();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic drain(input string tag, input int bound);
    int  c;
    bit  busy;
    c = 0;
    busy = 1;
    while (busy && c < bound) begin
      busy = m_full;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) busy = 1;
      if (busy) begin cycle(); c++; end
    end
    check(tag, c >= bound, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive();
    #1;
    check("rst_valid", sti_if.valid, 0);
    check("rst_grant", grant, 0);
    check("rst_perr", perr, 0);
    check("rst_stall", stall, 0);
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) seq[i] = 0;
    en = '0;
    model_reset();
    do_reset();

    // 1: single packet back to back
    push_pkt(0, 3);
    drive();
    cycle();
    check("t1_grant", grant, 3'b001);
    drain("t1_drain", 50);
    check("t1_count", n_out, 3);

    // 2: all SOP_EOP every cycle, rr order
    do_reset();
    out_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push_pkt(i, 1);
    drive();
    drain("t2_drain", 50);
    check("t2_count", out_log.size(), 6);
    for (int k = 0; k < out_log.size() && k < 6; k++)
      check("t2_order", out_log[k], k % 3);

    // 3: req0 SOP arrives during req1 packet
    push_pkt(1, 4);
    drive();
    run(2);
    push_pkt(0, 2);
    drive();
    drain("t3_drain", 50);

    // 4: backpressure mid-packet
    n_in = 0; n_out = 0;
    push_pkt(0, 6);
    drive();
    run(2);
    sti_hold = 5;
    drain("t4_drain", 50);
    check("t4_no_loss", n_out, 6);
    check("t4_in_out", n_in, n_out);

    // random packet traffic
    p_valid = 70;
    p_ready = 70;
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 6; p++) push_pkt(i, $urandom_range(5, 1));
    drive();
    drain("rand_drain", 5000);
    check("rand_in_out", n_in, n_out);

    // 5: orphan MOP, owner restart and owner stall
    p_valid = 100;
    p_ready = 100;
    push_raw(2, MOP);
    drive();
    run(3);
    check("t5_perr", perr, 3'b100);
    push_raw(0, SOP);
    push_raw(0, SOP);
    drive();
    run(300);
    check("t5_stall", stall, 1);
    check("t5_perr2", perr, 3'b101);

    // 6: reset mid-packet, then fresh packet from req0
    do_reset();
    push_pkt(0, 3);
    drive();
    cycle();
    check("t6_grant", grant, 3'b001);
    drain("t6_drain", 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
